// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-limited sharing of one fifo push port
// between two valid/ready producers.
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   req0_valid/data/ready       producer 0 handshake
//   req1_valid/data/ready       producer 1 handshake
//   fifo_full                   fifo back-pressure
//   fifo_push, fifo_push_data   push strobe and muxed winner data
//   grant_id                    current or last owner
//   busy                        high while a producer owns the port
//   cnt0, cnt1                  accepted-beat counters, wrapping
module fifo_push_arbiter #(
    parameter int BIT_WIDTH = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [BIT_WIDTH-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [BIT_WIDTH-1:0] req1_data,
    output logic                 req1_ready,
    input  logic                 fifo_full,
    output logic                 fifo_push,
    output logic [BIT_WIDTH-1:0] fifo_push_data,
    output logic                 grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN);

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic       rr_ptr_nxt;
    logic [3:0] beat_cnt;
    logic [3:0] beat_cnt_nxt;
    logic       grant_nxt;

    logic       win;
    logic       own;
    logic       own_valid;
    logic       xfer0;
    logic       xfer1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= 4'd0;
            grant_id <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            grant_id <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        grant_nxt    = grant_id;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        own          = 1'b0;
        own_valid    = 1'b0;
        // Contention resolves to rr_ptr; otherwise the lone valid wins.
        win = (req0_valid && req1_valid) ? rr_ptr : req1_valid;

        case (state)
            IDLE: begin
                if ((req0_valid || req1_valid) && !fifo_full) begin
                    req0_ready = !win;
                    req1_ready = win;
                    grant_nxt  = win;
                    if (BURST_LEN == 1) begin
                        // Single-beat bursts never park in OWNx.
                        rr_ptr_nxt = !win;
                    end else begin
                        state_nxt    = win ? OWN1 : OWN0;
                        beat_cnt_nxt = 4'd1;
                    end
                end
            end
            OWN0, OWN1: begin
                own       = (state == OWN1);
                own_valid = own ? req1_valid : req0_valid;
                if (!own_valid) begin
                    // Owner ended its burst early: one bubble, then rearbitrate.
                    state_nxt    = IDLE;
                    rr_ptr_nxt   = !own;
                    beat_cnt_nxt = 4'd0;
                end else if (!fifo_full) begin
                    req0_ready   = !own;
                    req1_ready   = own;
                    beat_cnt_nxt = beat_cnt + 4'd1;
                    if (beat_cnt_nxt == BURST_LAST) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = !own;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = 4'd0;
            end
        endcase

        // Handshake is combinational, so it must be masked while in reset.
        if (!rst) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign xfer0          = req0_valid && req0_ready;
    assign xfer1          = req1_valid && req1_ready;
    assign fifo_push      = xfer0 || xfer1;
    assign fifo_push_data = xfer1 ? req1_data : req0_data;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (xfer0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (xfer1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed checks of arbitration, bursts,
// back-pressure, early release and async reset.
module tb_fifo_push_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        fifo_full;
    logic        fifo_push;
    logic [7:0]  fifo_push_data;
    logic        grant_id;
    logic        busy;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int checks;
    int failures;

    fifo_push_arbiter #(
        .BIT_WIDTH(8),
        .BURST_LEN(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .fifo_full(fifo_full),
        .fifo_push(fifo_push),
        .fifo_push_data(fifo_push_data),
        .grant_id(grant_id),
        .busy(busy),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        fifo_full  = 1'b0;
        rst        = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
    endtask

    initial begin
        logic exp_own;
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'hA0;
        req1_data  = 8'hB0;
        fifo_full  = 1'b0;

        // T1: held in reset with both valid
        nxt();
        nxt();
        nxt();
        settle();
        chk("t1_rdy0", req0_ready, 0);
        chk("t1_rdy1", req1_ready, 0);
        chk("t1_push", fifo_push, 0);
        chk("t1_cnt0", cnt0, 0);
        chk("t1_cnt1", cnt1, 0);
        chk("t1_busy", busy, 0);
        chk("t1_grant", grant_id, 0);
        nxt();
        rst = 1'b1;
        settle();
        chk("t1_first_rdy", {req1_ready, req0_ready}, 2'b01);
        chk("t1_first_push", {fifo_push, fifo_push_data}, 9'h1A0);
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        chk("t1_own0", {busy, grant_id}, 2'b10);
        chk("t1_cnt0_1", cnt0, 1);

        // T2: single producer burst of four
        do_reset();
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_data = 8'h11 + 8'(i);
            settle();
            chk("t2_push", {fifo_push, fifo_push_data}, {1'b1, 8'h11 + 8'(i)});
            nxt();
        end
        req0_valid = 1'b0;
        settle();
        chk("t2_idle", {busy, fifo_push}, 2'b00);
        chk("t2_cnt0", cnt0, 4);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        settle();
        chk("t2_rr1", {req1_ready, req0_ready}, 2'b10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // T3: continuous contention, 16 beats
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_own   = ((i / 4) % 2) == 1;
            req0_data = 8'h20 + 8'(i);
            req1_data = 8'h30 + 8'(i);
            settle();
            chk("t3_beat", {fifo_push, req1_ready, req0_ready, fifo_push_data},
                {1'b1, exp_own, !exp_own,
                 exp_own ? 8'h30 + 8'(i) : 8'h20 + 8'(i)});
            nxt();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        chk("t3_cnt0", cnt0, 8);
        chk("t3_cnt1", cnt1, 8);
        chk("t3_busy", busy, 0);

        // T4: back-pressure mid-burst
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 8'h50;
        for (int i = 0; i < 2; i++) begin
            req0_data = 8'h40 + 8'(i);
            settle();
            chk("t4_pre", {fifo_push, fifo_push_data}, {1'b1, 8'h40 + 8'(i)});
            nxt();
        end
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_full", {busy, req1_ready, req0_ready, fifo_push}, 4'b1000);
            nxt();
        end
        fifo_full = 1'b0;
        for (int i = 2; i < 4; i++) begin
            req0_data = 8'h40 + 8'(i);
            settle();
            chk("t4_post", {fifo_push, req0_ready, fifo_push_data},
                {2'b11, 8'h40 + 8'(i)});
            nxt();
        end
        settle();
        chk("t4_req1", {fifo_push, req1_ready, req0_ready, fifo_push_data},
            {3'b110, 8'h50});
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        chk("t4_grant", grant_id, 1);
        chk("t4_cnts", {cnt0, cnt1}, {16'd4, 16'd1});

        // T5: owner drops valid early
        do_reset();
        req0_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0_data = 8'h60 + 8'(i);
            settle();
            chk("t5_beat", {fifo_push, fifo_push_data}, {1'b1, 8'h60 + 8'(i)});
            nxt();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 8'h70;
        settle();
        chk("t5_bubble", {busy, req1_ready, fifo_push}, 3'b100);
        nxt();
        settle();
        chk("t5_req1", {busy, req1_ready, fifo_push, fifo_push_data},
            {3'b011, 8'h70});
        nxt();
        req1_valid = 1'b0;
        settle();
        chk("t5_grant", {busy, grant_id}, 2'b11);
        chk("t5_cnts", {cnt0, cnt1}, {16'd2, 16'd1});

        // T6: reset pulse mid-burst in OWN1
        do_reset();
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req1_data = 8'h80 + 8'(i);
            settle();
            chk("t6_beat", {fifo_push, fifo_push_data}, {1'b1, 8'h80 + 8'(i)});
            nxt();
        end
        req0_valid = 1'b1;
        req1_data  = 8'h83;
        settle();
        chk("t6_pre", {busy, req1_ready, fifo_push}, 3'b111);
        rst = 1'b0;
        settle();
        chk("t6_drop", {busy, req1_ready, req0_ready, fifo_push}, 4'b0000);
        chk("t6_cnts", {cnt0, cnt1}, 32'd0);
        nxt();
        nxt();
        rst = 1'b1;
        settle();
        chk("t6_restart", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
